rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Request/acknowledge sequencer that drives the READ/WRITE port of the 32x32 register file on behalf of the datapath or testbench. It accepts one transaction at a time (read two source registers, write one destination, or both), guarantees READ and WRITE are never asserted together, and captures read data into holding registers. It sits between the control unit and the register file.

## Interface
Parameters:
- none; widths come from `DATA_INDEX_LIMIT` (31) and `REG_ADDR_INDEX_LIMIT` (4) in prj_definition.v

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- REQ  in  1  transaction request, level; held by requester until ACK
- OP_RD  in  1  transaction reads SRC1/SRC2
- OP_WR  in  1  transaction writes WDATA to DST
- SRC1, SRC2, DST  in  5 each  register addresses
- WDATA  in  32  write data
- ACK  out  1  one-cycle completion pulse
- BUSY  out  1  high in every state except IDLE
- RDATA1, RDATA2  out  32  captured read data, held until next read
- RF_READ, RF_WRITE  out  1  register-file strobes, mutually exclusive
- RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  5  register-file addresses
- RF_DATA_W  out  32  register-file write data
- RF_DATA_R1, RF_DATA_R2  in  32  register-file read data (combinational from RF)

## Operation
- States: IDLE, READ, WRITE, DONE (2-bit encoding).
- IDLE: if REQ=1, latch OP_RD, OP_WR, SRC1, SRC2, DST, WDATA; next = READ if OP_RD, else WRITE if OP_WR, else DONE (null op).
- READ: RF_READ=1, RF_WRITE=0, RF_ADDR_R1/R2 = latched SRC1/SRC2; on the closing edge, RDATA1/RDATA2 <= RF_DATA_R1/R2; next = WRITE if OP_WR, else DONE.
- WRITE: RF_WRITE=1, RF_READ=0, RF_ADDR_W = latched DST, RF_DATA_W = latched WDATA; next = DONE.
- DONE: ACK=1, both strobes 0; next = IDLE.
- Read always precedes write: a combined transaction with DST equal to SRC1 returns the pre-write value.
- RF address/data outputs reflect the latched fields in every state (stable, no glitching on request inputs).
- REQ outside IDLE is ignored; inputs are not re-latched mid-transaction.
- REQ still high in the IDLE cycle after DONE starts a new transaction (requester must drop REQ on ACK).
- RDATA1/RDATA2 change only in READ; write-only and null ops leave them unchanged.

## Timing
- Reset (RST=0, asynchronous): state IDLE; ACK, BUSY, RF_READ, RF_WRITE = 0; RDATA1/2, all RF address/data outputs = 0.
- Reset mid-transaction: strobes drop immediately, no ACK issued, latched fields cleared.
- REQ sampled at edge n: read-only ACK in cycle n+2; write-only ACK in n+2; read+write ACK in n+3; null op ACK in n+1.
- RDATA valid from the cycle after READ (DONE or WRITE) onward.
- BUSY rises the cycle after REQ is accepted and falls when IDLE is re-entered.
- Throughput: one transaction per 3 cycles (read or write), 4 cycles (both).

## Configuration
- RF_ACC_ZERO_REG_EN defined: register 0 reads as zero — RDATA1/RDATA2 capture 0 when the corresponding SRC = 0 regardless of RF data; a write with DST = 0 skips WRITE (RF_WRITE never asserted) and goes straight to DONE, ACK one cycle earlier.
- Undefined: register 0 is an ordinary register; reads and writes pass through unmodified.

## Structure
- State encodings (`RF_ACC_IDLE`, `RF_ACC_READ`, `RF_ACC_WRITE`, `RF_ACC_DONE`) added as defines to prj_definition.v; width limits reused from there.
- One sub-module: rf_acc_fsm (state register, next-state logic, strobe/ACK/BUSY decode); top level holds the request latches and RDATA capture registers.

## Test plan
- Reset then write-only: REQ, OP_WR=1, DST=5, WDATA=0xDEADBEEF -> RF_WRITE high exactly one cycle with RF_ADDR_W=5, ACK at n+2, RF_READ never high.
- Read-only after that: SRC1=5, SRC2=0 (RF R0=0) -> RF_READ one cycle, RDATA1=0xDEADBEEF, RDATA2=0, ACK at n+2.
- Combined read/write on same register: R7=0x11111111, SRC1=7, DST=7, WDATA=0x22222222 -> RDATA1=0x11111111, ACK at n+3, subsequent read of R7 returns 0x22222222.
- REQ toggled while BUSY with different fields -> ignored; completed transaction uses originally latched fields; exactly one ACK.
- Reset asserted during WRITE state -> RF_WRITE and BUSY drop without waiting for clock, no ACK, RDATA1/2 = 0.
- With RF_ACC_ZERO_REG_EN: write DST=0 WDATA=0xFFFFFFFF -> no RF_WRITE, ACK at n+1; read SRC1=0 with RF_DATA_R1 forced 0xABCD0123 -> RDATA1=0.

Source files
------------

// File: rtl/rf_access_ctrl_pkg.sv
// Shared widths, FSM encodings and request bundle for the register-file
// access sequencer.
package rf_access_ctrl_pkg;

    localparam int DATA_INDEX_LIMIT     = 31;
    localparam int REG_ADDR_INDEX_LIMIT = 4;

    localparam logic [1:0] RF_ACC_IDLE  = 2'd0;
    localparam logic [1:0] RF_ACC_READ  = 2'd1;
    localparam logic [1:0] RF_ACC_WRITE = 2'd2;
    localparam logic [1:0] RF_ACC_DONE  = 2'd3;

    typedef logic [DATA_INDEX_LIMIT:0]     data_t;
    typedef logic [REG_ADDR_INDEX_LIMIT:0] addr_t;

    typedef struct packed {
        logic  op_wr;
        addr_t src1;
        addr_t src2;
        addr_t dst;
        data_t wdata;
    } rf_req_t;

    function automatic logic is_zero_reg(input addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/rf_acc_fsm.sv
// Sequencer state machine: IDLE -> [READ] -> [WRITE] -> DONE.
// Strobes, ACK and BUSY are decoded straight from the state register.
module rf_acc_fsm
    import rf_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic op_rd,
    input  logic op_wr,
    input  logic op_wr_q,
    output logic load,
    output logic rd_cap,
    output logic rf_read,
    output logic rf_write,
    output logic ack,
    output logic busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RF_ACC_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RF_ACC_IDLE: begin
                if (req) begin
                    if (op_rd)      state_nxt = RF_ACC_READ;
                    else if (op_wr) state_nxt = RF_ACC_WRITE;
                    else            state_nxt = RF_ACC_DONE;
                end
            end
            RF_ACC_READ:  state_nxt = op_wr_q ? RF_ACC_WRITE : RF_ACC_DONE;
            RF_ACC_WRITE: state_nxt = RF_ACC_DONE;
            RF_ACC_DONE:  state_nxt = RF_ACC_IDLE;
            default:      state_nxt = RF_ACC_IDLE;
        endcase
    end

    assign load     = (state == RF_ACC_IDLE) && req;
    assign rf_read  = (state == RF_ACC_READ);
    assign rd_cap   = rf_read;
    assign rf_write = (state == RF_ACC_WRITE);
    assign ack      = (state == RF_ACC_DONE);
    assign busy     = (state != RF_ACC_IDLE);

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: latches one request, reads then writes.
// Define RF_ACC_ZERO_REG_EN to make register 0 read as zero and ignore writes.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  REQ,
    input  logic  OP_RD,
    input  logic  OP_WR,
    input  addr_t SRC1,
    input  addr_t SRC2,
    input  addr_t DST,
    input  data_t WDATA,
    output logic  ACK,
    output logic  BUSY,
    output data_t RDATA1,
    output data_t RDATA2,
    output logic  RF_READ,
    output logic  RF_WRITE,
    output addr_t RF_ADDR_R1,
    output addr_t RF_ADDR_R2,
    output addr_t RF_ADDR_W,
    output data_t RF_DATA_W,
    input  data_t RF_DATA_R1,
    input  data_t RF_DATA_R2
);

    rf_req_t req_q;
    logic    wr_eff;
    logic    load;
    logic    rd_cap;
    data_t   rd1_val;
    data_t   rd2_val;

`ifdef RF_ACC_ZERO_REG_EN
    // A write to r0 is dropped at accept time so the FSM skips WRITE.
    assign wr_eff  = OP_WR && !is_zero_reg(DST);
    assign rd1_val = is_zero_reg(req_q.src1) ? '0 : RF_DATA_R1;
    assign rd2_val = is_zero_reg(req_q.src2) ? '0 : RF_DATA_R2;
`else
    assign wr_eff  = OP_WR;
    assign rd1_val = RF_DATA_R1;
    assign rd2_val = RF_DATA_R2;
`endif

    rf_acc_fsm u_fsm (
        .clk      (CLK),
        .rst_n    (RST),
        .req      (REQ),
        .op_rd    (OP_RD),
        .op_wr    (wr_eff),
        .op_wr_q  (req_q.op_wr),
        .load     (load),
        .rd_cap   (rd_cap),
        .rf_read  (RF_READ),
        .rf_write (RF_WRITE),
        .ack      (ACK),
        .busy     (BUSY)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_q <= '0;
        end else if (load) begin
            req_q.op_wr <= wr_eff;
            req_q.src1  <= SRC1;
            req_q.src2  <= SRC2;
            req_q.dst   <= DST;
            req_q.wdata <= WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RDATA1 <= '0;
            RDATA2 <= '0;
        end else if (rd_cap) begin
            RDATA1 <= rd1_val;
            RDATA2 <= rd2_val;
        end
    end

    assign RF_ADDR_R1 = req_q.src1;
    assign RF_ADDR_R2 = req_q.src2;
    assign RF_ADDR_W  = req_q.dst;
    assign RF_DATA_W  = req_q.wdata;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl with a behavioural 32x32 register file.
// Covers latency, strobes, read-before-write, REQ glitching and async reset.
module tb_rf_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ, OP_RD, OP_WR;
    logic [4:0]  SRC1, SRC2, DST;
    logic [31:0] WDATA;
    logic        ACK, BUSY, RF_READ, RF_WRITE;
    logic [31:0] RDATA1, RDATA2, RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;

    always #5 CLK = ~CLK;

    rf_access_ctrl dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP_RD(OP_RD), .OP_WR(OP_WR),
        .SRC1(SRC1), .SRC2(SRC2), .DST(DST), .WDATA(WDATA),
        .ACK(ACK), .BUSY(BUSY), .RDATA1(RDATA1), .RDATA2(RDATA2),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
        .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
        .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    logic [31:0] rf_mem [32] = '{default: '0};
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;

    always @(posedge CLK)
        if (RF_WRITE) rf_mem[RF_ADDR_W] <= RF_DATA_W;

    assign RF_DATA_R1 = (force_en && RF_ADDR_R1 == 5'd0) ? force_val
                                                         : rf_mem[RF_ADDR_R1];
    assign RF_DATA_R2 = rf_mem[RF_ADDR_R2];

`ifdef RF_ACC_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          lat;
        logic [31:0] r1;
        logic [31:0] r2;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_rf [32];
    logic [31:0] last_r1 = '0;
    logic [31:0] last_r2 = '0;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (ZR && a == 5'd0) ? 32'd0 : ref_rf[a];
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d,
                       input logic [31:0] wd, input bit glitch);
        exp_t e;
        exp_t got_e;
        bit   wr_eff;
        int   k;
        int   nr;
        int   nw;
        bit   got;
        wr_eff = wr && !(ZR && d == 5'd0);
        e.r1  = rd ? ref_rd(s1) : last_r1;
        e.r2  = rd ? ref_rd(s2) : last_r2;
        e.nrd = rd ? 1 : 0;
        e.nwr = wr_eff ? 1 : 0;
        e.lat = 1 + e.nrd + e.nwr;
        last_r1 = e.r1;
        last_r2 = e.r2;
        if (wr_eff) ref_rf[d] = wd;
        sb.push_back(e);
        @(negedge CLK);
        REQ = 1'b1; OP_RD = rd; OP_WR = wr;
        SRC1 = s1; SRC2 = s2; DST = d; WDATA = wd;
        k = 0; nr = 0; nw = 0; got = 1'b0;
        while (!got && k < 10) begin
            @(negedge CLK);
            k++;
            if (k == 1) chk("busy_rise", BUSY, 1);
            if (glitch) begin
                REQ   = ~REQ;
                OP_RD = 1'($urandom);
                OP_WR = 1'($urandom);
                SRC1  = 5'($urandom);
                SRC2  = 5'($urandom);
                DST   = 5'($urandom);
                WDATA = $urandom;
            end
            chk("strobe_excl", RF_READ & RF_WRITE, 0);
            if (RF_READ) begin
                nr++;
                chk("addr_r1", RF_ADDR_R1, s1);
                chk("addr_r2", RF_ADDR_R2, s2);
            end
            if (RF_WRITE) begin
                nw++;
                chk("addr_w", RF_ADDR_W, d);
                chk("data_w", RF_DATA_W, wd);
            end
            if (ACK) begin
                got = 1'b1;
                REQ = 1'b0;
            end
        end
        REQ = 1'b0;
        got_e = sb.pop_front();
        chk("ack_seen", got, 1);
        chk("ack_lat", k, got_e.lat);
        chk("rdata1", RDATA1, got_e.r1);
        chk("rdata2", RDATA2, got_e.r2);
        chk("n_read", nr, got_e.nrd);
        chk("n_write", nw, got_e.nwr);
        @(negedge CLK);
        chk("ack_once", ACK, 0);
        chk("busy_idle", BUSY, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        REQ = 0; OP_RD = 0; OP_WR = 0;
        SRC1 = 0; SRC2 = 0; DST = 0; WDATA = 0;
        #12;
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rd", RF_READ, 0);
        chk("rst_wr", RF_WRITE, 0);
        chk("rst_rdata1", RDATA1, 0);
        chk("rst_addr_w", RF_ADDR_W, 0);
        chk("rst_data_w", RF_DATA_W, 0);
        @(negedge CLK);
        RST = 1'b1;

        txn(0, 1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 0);
        txn(1, 0, 5'd5, 5'd0, 5'd0, 32'h0, 0);
        txn(0, 1, 5'd0, 5'd0, 5'd7, 32'h11111111, 0);
        txn(1, 1, 5'd7, 5'd5, 5'd7, 32'h22222222, 0);
        txn(1, 0, 5'd7, 5'd7, 5'd0, 32'h0, 0);
        txn(0, 0, 5'd3, 5'd4, 5'd6, 32'h12345678, 0);
        txn(0, 1, 5'd0, 5'd0, 5'd9, 32'h33333333, 0);
        txn(1, 1, 5'd9, 5'd5, 5'd10, 32'h44444444, 1);
        txn(1, 0, 5'd10, 5'd9, 5'd0, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            txn(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom_range(1, 31)), $urandom, 1'(i & 1));

        // Reset lands mid-WRITE, before the closing edge.
        @(negedge CLK);
        REQ = 1'b1; OP_RD = 1'b0; OP_WR = 1'b1;
        DST = 5'd12; WDATA = 32'h55555555;
        @(negedge CLK);
        chk("pre_rst_wr", RF_WRITE, 1);
        REQ = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("mrst_wr", RF_WRITE, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_ack", ACK, 0);
        chk("mrst_rdata1", RDATA1, 0);
        chk("mrst_rdata2", RDATA2, 0);
        chk("mrst_addr_w", RF_ADDR_W, 0);
        chk("mrst_data_w", RF_DATA_W, 0);
        last_r1 = '0;
        last_r2 = '0;
        @(negedge CLK);
        chk("mrst_ack2", ACK, 0);
        RST = 1'b1;
        txn(1, 0, 5'd12, 5'd7, 5'd0, 32'h0, 0);

`ifdef RF_ACC_ZERO_REG_EN
        txn(0, 1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 0);
        force_val = 32'hABCD0123;
        force_en  = 1'b1;
        txn(1, 0, 5'd0, 5'd7, 5'd0, 32'h0, 0);
        force_en  = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
